serial_frame_rx: RTL and testbench

Synchronous serial frame receiver: the reading end of a single-bit registered data line (`din`) driven one bit per clock by a serializer or DFF chain. It detects a start bit, shifts in a fixed-width data word, optionally checks even parity, validates the stop bit, and presents the word on a parallel output with a one-cycle valid strobe. It sits between a bit-serial link and byte-oriented logic.

---
 rtl/serial_frame_rx.sv | 140 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_BITS data, optional even parity, stop bit.
// One sample per clock; outputs registered; strobes land on the stop-sampling edge.
module serial_frame_rx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_din,
  output logic [DATA_BITS-1:0] o_q,
  output logic                 o_valid,
  output logic                 o_par_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int            CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_shift;
  logic [DATA_BITS-1:0] r_q;
  logic [CW-1:0]        r_cnt;
  logic                 r_mismatch;
  logic                 r_valid;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_busy;

  logic w_start;
  logic w_shift;
  logic w_par_smp;
  logic w_good;
  logic w_bad;

  // Direction of shift decides which end the first data bit lands in.
  generate
    if (DATA_BITS == 1) begin : g_one
      assign w_shreg_shift = i_din;
    end else if (LSB_FIRST != 0) begin : g_lsb
      assign w_shreg_shift = {i_din, r_shreg[DATA_BITS-1:1]};
    end else begin : g_msb
      assign w_shreg_shift = {r_shreg[DATA_BITS-2:0], i_din};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_din) begin
          w_start     = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_par_smp   = 1'b1;
        w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (i_din) begin
          w_good      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_bad       = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        // The first 1 after a break only ends it; it can never be a start bit.
        if (i_din) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_mismatch  <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_valid     <= w_good;
      r_par_err   <= w_good & r_mismatch;
      r_frame_err <= w_bad;
      if (w_start) begin
        r_cnt      <= '0;
        r_mismatch <= 1'b0;
      end else if (w_shift) begin
        r_shreg <= w_shreg_shift;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_par_smp) begin
        r_mismatch <= ^{r_shreg, i_din};
      end
      if (w_good) begin
        r_q <= r_shreg;
      end
    end
  end

  assign o_q         = r_q;
  assign o_valid     = r_valid;
  assign o_par_err   = r_par_err;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench: plain LSB-first, parity and MSB-first receivers driven from one sequence.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       din_p = 1'b1;

  logic [7:0] q0, q1, q2;
  logic       valid0, valid1, valid2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_BITS(8), .PARITY_EN(0), .LSB_FIRST(1)) u_plain (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_q(q0), .o_valid(valid0),
    .o_par_err(perr0), .o_frame_err(ferr0), .o_busy(busy0));

  serial_frame_rx #(.DATA_BITS(8), .PARITY_EN(1), .LSB_FIRST(1)) u_par (
    .i_clk(clk), .i_rst(rst), .i_din(din_p), .o_q(q1), .o_valid(valid1),
    .o_par_err(perr1), .o_frame_err(ferr1), .o_busy(busy1));

  serial_frame_rx #(.DATA_BITS(8), .PARITY_EN(0), .LSB_FIRST(0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_q(q2), .o_valid(valid2),
    .o_par_err(perr2), .o_frame_err(ferr2), .o_busy(busy2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit on the selected line (the other idles at 1), then settle past the sampling edge.
  task automatic drive(input bit sel, input logic b);
    if (sel) begin
      din_p = b;
      din   = 1'b1;
    end else begin
      din   = b;
      din_p = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int strobes(input bit sel);
    if (sel) return int'(valid1) + int'(perr1) + int'(ferr1);
    return int'(valid0) + int'(perr0) + int'(ferr0);
  endfunction

  // Sends start, data LSB-first, optional parity, then stop; counts strobes seen before the stop edge.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par_b, input logic stop_b, output int early);
    early = 0;
    drive(sel, 1'b0);
    early += strobes(sel);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      early += strobes(sel);
    end
    if (with_par) begin
      drive(sel, par_b);
      early += strobes(sel);
    end
    drive(sel, stop_b);
  endtask

  initial begin
    int early;
    int seen;

    // Reset
    rst = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("rst_q", {8'h0, q0}, 16'h0000);
    chk("rst_valid", {15'h0, valid0}, 16'h0);
    chk("rst_busy", {15'h0, busy0}, 16'h0);
    chk("rst_ferr", {15'h0, ferr0}, 16'h0);
    chk("rst_perr", {15'h0, perr1}, 16'h0);
    rst = 1'b0;

    // Idle line for 50 cycles
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1);
      seen += int'(busy0) + int'(valid0) + int'(ferr0);
    end
    chk("idle_activity", seen[15:0], 16'h0);
    chk("idle_q", {8'h0, q0}, 16'h0000);

    // Single good frame 0xA5
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, early);
    chk("a5_early", early[15:0], 16'h0);
    chk("a5_valid", {15'h0, valid0}, 16'h1);
    chk("a5_q", {8'h0, q0}, 16'h00A5);
    chk("a5_perr", {15'h0, perr0}, 16'h0);
    chk("a5_ferr", {15'h0, ferr0}, 16'h0);
    chk("a5_busy_fall", {15'h0, busy0}, 16'h0);
    chk("a5_msb_q", {8'h0, q2}, 16'h00A5);

    // Back-to-back 0x3C then 0xC3, zero idle gap
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, early);
    chk("3c_early", early[15:0], 16'h0);
    chk("3c_valid", {15'h0, valid0}, 16'h1);
    chk("3c_q", {8'h0, q0}, 16'h003C);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, early);
    chk("c3_gap_no_strobe", early[15:0], 16'h0);
    chk("c3_valid", {15'h0, valid0}, 16'h1);
    chk("c3_q", {8'h0, q0}, 16'h00C3);

    // Framing error: 0x55 with stop=0, line held low
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, early);
    chk("fe_early", early[15:0], 16'h0);
    chk("fe_ferr", {15'h0, ferr0}, 16'h1);
    chk("fe_valid", {15'h0, valid0}, 16'h0);
    chk("fe_q_hold", {8'h0, q0}, 16'h00C3);
    chk("fe_busy", {15'h0, busy0}, 16'h1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      seen += int'(ferr0) + int'(valid0) + int'(!busy0);
    end
    chk("break_hold", seen[15:0], 16'h0);
    drive(1'b0, 1'b1);
    chk("break_exit_busy", {15'h0, busy0}, 16'h0);
    chk("break_exit_valid", {15'h0, valid0}, 16'h0);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, early);
    chk("0f_valid", {15'h0, valid0}, 16'h1);
    chk("0f_q", {8'h0, q0}, 16'h000F);
    chk("0f_msb_q", {8'h0, q2}, 16'h00F0);
    drive(1'b0, 1'b1);
    chk("0f_valid_drop", {15'h0, valid0}, 16'h0);

    // Parity instance
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, early);
    chk("par_ok_early", early[15:0], 16'h0);
    chk("par_ok_valid", {15'h0, valid1}, 16'h1);
    chk("par_ok_perr", {15'h0, perr1}, 16'h0);
    chk("par_ok_q", {8'h0, q1}, 16'h0007);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, early);
    chk("par_bad_valid", {15'h0, valid1}, 16'h1);
    chk("par_bad_perr", {15'h0, perr1}, 16'h1);
    drive(1'b1, 1'b1);
    chk("par_bad_perr_drop", {15'h0, perr1}, 16'h0);

    // Reset mid-frame after the 4th data bit
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    chk("mid_busy", {15'h0, busy0}, 16'h1);
    rst = 1'b1;
    drive(1'b0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_valid", {15'h0, valid0}, 16'h0);
    chk("mid_rst_ferr", {15'h0, ferr0}, 16'h0);
    chk("mid_rst_q", {8'h0, q0}, 16'h0000);
    chk("mid_rst_busy", {15'h0, busy0}, 16'h0);
    chk("mid_rst_msb_q", {8'h0, q2}, 16'h0000);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, early);
    chk("81_valid", {15'h0, valid0}, 16'h1);
    chk("81_q", {8'h0, q0}, 16'h0081);
    chk("81_msb_q", {8'h0, q2}, 16'h0081);
    chk("81_msb_first_bit", {15'h0, q2[7]}, 16'h1);
    drive(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
